wash_cycle_ctrl: RTL and testbench
==================================

# wash_cycle_ctrl

Self-timed washing-machine cycle controller and the parametrised successor of the team's fixed-sequence FSM. It integrates the per-phase seconds timer and the clock-frequency prescaler, and adds an optional double-wash pass, spin-only pause and a live countdown output. It sits between the coin/door front panel and the motor/valve drivers, which decode `state`.

## Interface
Parameters:
- `FILL_SEC`, default 120: fill-water phase duration, seconds.
- `WASH_SEC`, default 300: wash phase duration, seconds.
- `RINSE_SEC`, default 120: rinse phase duration, seconds.
- `SPIN_SEC`, default 60: spin phase duration, seconds.
- `BASE_TICKS`, default 1000000: clk cycles per second when `clk_freq`=0.
- `SEC_W`, default 9: width of the seconds counter.
- Constraints: every `*_SEC` is between 1 and 2^SEC_W−1.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `clk_freq`, in, 2: clk rate code; ticks per second T = BASE_TICKS << clk_freq.
- `coin_in`, in, 1: level; starts a cycle when sampled high in IDLE.
- `double_wash`, in, 1: request a second wash+rinse pass.
- `timer_pause`, in, 1: freezes the timer, honoured in SPIN only.
- `state`, out, 3: IDLE=000, FILL=001, WASH=011, RINSE=111, SPIN=110.
- `sec_left`, out, SEC_W: seconds remaining in the current phase. 0 in IDLE.
- `wash_pass`, out, 1: 0 during the first pass, 1 during the second wash/rinse pass.
- `busy`, out, 1: high when `state` is not IDLE.
- `wash_done`, out, 1: one-cycle completion pulse.

## Operation
- Reset values: `state`=IDLE, `sec_left`=0, `wash_pass`=0, `busy`=0, `wash_done`=0, prescaler=0, latched mode bits=0.
- Coin acceptance happens at a clock edge where `state`=IDLE and `coin_in`=1:
  - `clk_freq` is latched to `freq_q`.
  - `double_wash` is latched to `dbl_q`.
  - `state` becomes FILL, `sec_left` becomes FILL_SEC, prescaler clears.
- `coin_in` is ignored outside IDLE. `clk_freq` and `double_wash` are also ignored after acceptance; only the latched values are used.
- Prescaler:
  - Counts 0..T−1, with T taken from `freq_q`.
  - `sec_tick` is asserted when the prescaler equals T−1, and the prescaler wraps to 0.
  - Width is sized for BASE_TICKS·8.
- On `sec_tick`:
  - If `sec_left` > 1: decrement `sec_left`.
  - If `sec_left` = 1: the phase ends. The next state is entered at the next edge, `sec_left` loads the new phase duration and the prescaler restarts at 0.
- Phase transitions:
  - FILL → WASH
  - WASH → RINSE
  - RINSE → WASH, only if `dbl_q`=1 and `wash_pass`=0. This sets `wash_pass`=1.
  - RINSE → SPIN, otherwise.
  - SPIN → IDLE. `sec_left` becomes 0, `wash_pass` becomes 0 and `wash_done` pulses.
- Pause:
  - While `state`=SPIN and `timer_pause`=1, the prescaler and `sec_left` hold. Releasing pause resumes from the held values.
  - `timer_pause` has no effect in any other state.
- `wash_done` is registered. It is high for exactly the first cycle with `state`=IDLE after SPIN, and low otherwise.
- Unreachable `state` encodings go to IDLE at the next edge with `sec_left`=0.

## Timing
- Coin accepted at edge k: `state`=FILL from k+1.
- Each phase lasts exactly DUR·T cycles, plus any cycles paused in SPIN.
- Single cycle length, coin edge to IDLE: (FILL+WASH+RINSE+SPIN)·T cycles.
- Double wash adds (WASH+RINSE)·T cycles.
- `busy` is combinational from `state`. All other outputs are registered.
- `rst_n` asserted mid-cycle aborts immediately: all outputs take their reset values asynchronously. No `wash_done` is produced.
- `timer_pause` rising at the same edge as the final `sec_tick` of SPIN: the pause wins, and the phase holds with `sec_left`=1.
- `coin_in` held high through the `wash_done` cycle: a new cycle is accepted at that edge, so `state`=FILL on the following cycle.

## Test plan
All scenarios use BASE_TICKS=4, FILL=2, WASH=3, RINSE=2, SPIN=1, SEC_W=4.
- Single cycle: `clk_freq`=0, coin pulse 1 cycle → `state` 001,011,111,110 for 8,12,8,4 cycles; IDLE after 32 cycles; `wash_done` high 1 cycle; `sec_left` counts 2,1 / 3,2,1 / 2,1 / 1.
- Double wash: `double_wash`=1 at coin → sequence FILL,WASH,RINSE,WASH,RINSE,SPIN; `wash_pass`=1 for the second WASH/RINSE; total 52 cycles.
- Frequency scaling: `clk_freq`=2 (T=16), then `clk_freq` toggled mid-cycle → total exactly 128 cycles.
- Pause: `timer_pause` high 10 cycles during WASH → no effect (32 total); high 10 cycles during SPIN → SPIN lasts 14 cycles, total 42.
- Reset mid-RINSE: `rst_n` low 1 cycle → `state`=000, `sec_left`=0, `wash_pass`=0, no `wash_done`; a new coin restarts from FILL with `sec_left`=2.
- Back-to-back: `coin_in` held high continuously → `wash_done` every 33 cycles (32 active + 1 IDLE cycle), with no extra idle cycles.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// wash_cycle_ctrl
//
// Self-timed washing-machine cycle controller. A coin in IDLE starts the
// sequence FILL -> WASH -> RINSE -> [WASH -> RINSE] -> SPIN -> IDLE. Each phase
// lasts its *_SEC duration in seconds. One second is T = BASE_TICKS << freq_q
// clock cycles, counted by an internal prescaler.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   clk_freq     in   [1:0] clock-rate code, latched at coin acceptance
//   coin_in      in   level; starts a cycle when sampled high in IDLE
//   double_wash  in   request a second wash+rinse pass, latched at coin
//   timer_pause  in   freezes the timer, honoured in SPIN only
//   state        out  [2:0] IDLE=000 FILL=001 WASH=011 RINSE=111 SPIN=110
//   sec_left     out  [SEC_W-1:0] seconds left in the current phase (0 in IDLE)
//   wash_pass    out  1 during the second wash/rinse pass
//   busy         out  state != IDLE (combinational)
//   wash_done    out  one-cycle pulse on the first IDLE cycle after SPIN
//
// Handshake: there is no valid/ready pair. coin_in is a level that is consumed
// on any rising clk edge where state is IDLE. It is ignored in every other
// state, so holding it high restarts the machine on the wash_done cycle.
// -----------------------------------------------------------------------------
module wash_cycle_ctrl #(
  parameter int unsigned FILL_SEC   = 120,
  parameter int unsigned WASH_SEC   = 300,
  parameter int unsigned RINSE_SEC  = 120,
  parameter int unsigned SPIN_SEC   = 60,
  parameter int unsigned BASE_TICKS = 1000000,
  parameter int unsigned SEC_W      = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       clk_freq,
  input  logic             coin_in,
  input  logic             double_wash,
  input  logic             timer_pause,
  output logic [2:0]       state,
  output logic [SEC_W-1:0] sec_left,
  output logic             wash_pass,
  output logic             busy,
  output logic             wash_done
);

  // The prescaler must reach T-1 for the slowest rate code (<< 3).
  localparam int unsigned PW = $clog2(BASE_TICKS * 8);

  localparam logic [SEC_W-1:0] FILL_L  = SEC_W'(FILL_SEC);
  localparam logic [SEC_W-1:0] WASH_L  = SEC_W'(WASH_SEC);
  localparam logic [SEC_W-1:0] RINSE_L = SEC_W'(RINSE_SEC);
  localparam logic [SEC_W-1:0] SPIN_L  = SEC_W'(SPIN_SEC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FILL  = 3'b001,
    S_WASH  = 3'b011,
    S_RINSE = 3'b111,
    S_SPIN  = 3'b110
  } state_e;

  state_e           state_q;
  logic [SEC_W-1:0] sec_q;
  logic             pass_q;
  logic             done_q;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic [1:0]       freq_q;
  logic             dbl_q;

  logic [PW-1:0]    tick_lim;
  logic             busy_w;
  logic             hold;
  logic             sec_tick;
  logic             phase_end;

  assign tick_lim  = PW'((BASE_TICKS << freq_q) - 1);
  assign busy_w    = (state_q != S_IDLE);
  // Pause only freezes SPIN. When it coincides with the final tick, the tick
  // is suppressed, so the phase holds with sec_left = 1.
  assign hold      = (state_q == S_SPIN) && timer_pause;
  assign sec_tick  = busy_w && (pre_q == tick_lim) && !hold;
  assign phase_end = sec_tick && (sec_q == SEC_W'(1));

  always_comb begin
    pre_d = pre_q;
    if (!busy_w || sec_tick) begin
      pre_d = '0;
    end else if (!hold) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sec_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      freq_q  <= 2'b00;
      dbl_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      done_q <= 1'b0;
      if (sec_tick && !phase_end) begin
        sec_q <= sec_q - SEC_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (coin_in) begin
            freq_q  <= clk_freq;
            dbl_q   <= double_wash;
            state_q <= S_FILL;
            sec_q   <= FILL_L;
          end
        end
        S_FILL: begin
          if (phase_end) begin
            state_q <= S_WASH;
            sec_q   <= WASH_L;
          end
        end
        S_WASH: begin
          if (phase_end) begin
            state_q <= S_RINSE;
            sec_q   <= RINSE_L;
          end
        end
        S_RINSE: begin
          if (phase_end) begin
            if (dbl_q && !pass_q) begin
              state_q <= S_WASH;
              sec_q   <= WASH_L;
              pass_q  <= 1'b1;
            end else begin
              state_q <= S_SPIN;
              sec_q   <= SPIN_L;
            end
          end
        end
        S_SPIN: begin
          if (phase_end) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          sec_q   <= '0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign sec_left  = sec_q;
  assign wash_pass = pass_q;
  assign wash_done = done_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_ctrl
//
// Directed bench for wash_cycle_ctrl with BASE_TICKS=4, FILL=2, WASH=3,
// RINSE=2, SPIN=1, SEC_W=4. A vector table holds whole-cycle scenarios with
// hand-computed phase lengths. Hand-written sequences cover the sec_left
// trace, pause on the final tick, mid-cycle reset and back-to-back coins.
// -----------------------------------------------------------------------------
module tb_wash_cycle_ctrl;

  localparam int SEC_W = 4;
  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_FILL  = 3'b001;
  localparam logic [2:0] ST_WASH  = 3'b011;
  localparam logic [2:0] ST_RINSE = 3'b111;
  localparam logic [2:0] ST_SPIN  = 3'b110;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       clk_freq = 2'b00;
  logic             coin_in = 1'b0;
  logic             double_wash = 1'b0;
  logic             timer_pause = 1'b0;
  logic [2:0]       state;
  logic [SEC_W-1:0] sec_left;
  logic             wash_pass;
  logic             busy;
  logic             wash_done;

  int checks = 0;
  int errors = 0;

  // Expected {state, sec_left} per cycle for the single-cycle trace.
  logic [6:0] exp_q[$];

  typedef struct {
    logic [1:0] freq;
    logic       dbl;
    logic [2:0] pause_st;   // ST_IDLE means no pause
    int         pause_len;
    logic       toggle;     // change clk_freq right after acceptance
    int         exp_total;
    int         exp_fill;
    int         exp_wash;
    int         exp_rinse;
    int         exp_spin;
    int         exp_washes;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    int         sec;
    int         reps;
  } seg_t;

  vec_t vecs[7];
  seg_t segs[8];

  wash_cycle_ctrl #(
    .FILL_SEC   (2),
    .WASH_SEC   (3),
    .RINSE_SEC  (2),
    .SPIN_SEC   (1),
    .BASE_TICKS (4),
    .SEC_W      (SEC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_freq    (clk_freq),
    .coin_in     (coin_in),
    .double_wash (double_wash),
    .timer_pause (timer_pause),
    .state       (state),
    .sec_left    (sec_left),
    .wash_pass   (wash_pass),
    .busy        (busy),
    .wash_done   (wash_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output logic ok);
    int n;
    n = 0;
    while (state !== st && n < budget) begin
      step();
      n++;
    end
    ok = (state === st);
  endtask

  // ---------------- driver tasks ----------------
  task automatic coin_pulse(input logic [1:0] freq, input logic dbl);
    clk_freq    = freq;
    double_wash = dbl;
    coin_in     = 1'b1;
    step();
    coin_in     = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, n_fill, n_wash, n_rinse, n_spin, washes, bad, pause_rem;
    logic [2:0] prev;
    string tag;
    cyc = 0; n_fill = 0; n_wash = 0; n_rinse = 0; n_spin = 0;
    washes = 0; bad = 0; pause_rem = v.pause_len; prev = ST_IDLE;
    tag = $sformatf("v%0d", idx);
    coin_pulse(v.freq, v.dbl);
    // Inputs changed after acceptance must be ignored.
    double_wash = ~v.dbl;
    if (v.toggle) clk_freq = ~v.freq;
    while (state !== ST_IDLE && cyc < 1000) begin
      cyc++;
      case (state)
        ST_FILL:  n_fill++;
        ST_WASH:  n_wash++;
        ST_RINSE: n_rinse++;
        ST_SPIN:  n_spin++;
        default:  bad++;
      endcase
      if (state === ST_WASH && prev !== ST_WASH) washes++;
      if ((state === ST_WASH || state === ST_RINSE) && wash_pass !== (washes == 2)) bad++;
      if (wash_done !== 1'b0 || busy !== 1'b1) bad++;
      if (state === v.pause_st && pause_rem > 0) begin
        timer_pause = 1'b1;
        pause_rem--;
      end else begin
        timer_pause = 1'b0;
      end
      prev = state;
      step();
    end
    timer_pause = 1'b0;
    check({tag, "_total"}, cyc, v.exp_total);
    check({tag, "_fill"}, n_fill, v.exp_fill);
    check({tag, "_wash"}, n_wash, v.exp_wash);
    check({tag, "_rinse"}, n_rinse, v.exp_rinse);
    check({tag, "_spin"}, n_spin, v.exp_spin);
    check({tag, "_washes"}, washes, v.exp_washes);
    check({tag, "_flags"}, bad, 0);
    check({tag, "_done_hi"}, wash_done, 1);
    check({tag, "_idle_sec"}, sec_left, 0);
    check({tag, "_idle_pass"}, wash_pass, 0);
    check({tag, "_idle_busy"}, busy, 0);
    step();
    check({tag, "_done_lo"}, wash_done, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic ok;
    int   t, first, second, seen;
    logic [6:0] e;

    // T = 4 << freq; durations 2,3,2,1 seconds.
    vecs[0] = '{2'd0, 1'b0, ST_IDLE,  0, 1'b0,  32,  8, 12,  8,  4, 1};
    vecs[1] = '{2'd0, 1'b1, ST_IDLE,  0, 1'b0,  52,  8, 24, 16,  4, 2};
    vecs[2] = '{2'd2, 1'b0, ST_IDLE,  0, 1'b1, 128, 32, 48, 32, 16, 1};
    vecs[3] = '{2'd0, 1'b0, ST_WASH, 10, 1'b0,  32,  8, 12,  8,  4, 1};
    vecs[4] = '{2'd0, 1'b0, ST_SPIN, 10, 1'b0,  42,  8, 12,  8, 14, 1};
    vecs[5] = '{2'd1, 1'b1, ST_IDLE,  0, 1'b1, 104, 16, 48, 32,  8, 2};
    vecs[6] = '{2'd3, 1'b0, ST_IDLE,  0, 1'b0, 256, 64, 96, 64, 32, 1};

    segs[0] = '{ST_FILL,  2, 4};
    segs[1] = '{ST_FILL,  1, 4};
    segs[2] = '{ST_WASH,  3, 4};
    segs[3] = '{ST_WASH,  2, 4};
    segs[4] = '{ST_WASH,  1, 4};
    segs[5] = '{ST_RINSE, 2, 4};
    segs[6] = '{ST_RINSE, 1, 4};
    segs[7] = '{ST_SPIN,  1, 4};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, ST_IDLE);
    check("rst_sec", sec_left, 0);
    check("rst_pass", wash_pass, 0);
    check("rst_busy", busy, 0);
    check("rst_done", wash_done, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_state", state, ST_IDLE);

    // Single cycle, cycle-by-cycle state and sec_left trace
    foreach (segs[i]) begin
      logic [3:0] s4;
      s4 = 4'(segs[i].sec);
      for (int r = 0; r < segs[i].reps; r++) exp_q.push_back({segs[i].st, s4});
    end
    coin_pulse(2'd0, 1'b0);
    t = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("trace_c%0d", t), {state, sec_left}, e);
      step();
      t++;
    end
    check("trace_idle", state, ST_IDLE);
    check("trace_done", wash_done, 1);
    step();

    // Table-driven whole cycles
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Pause rising on the same edge as the final SPIN tick
    coin_pulse(2'd0, 1'b0);
    wait_state(ST_SPIN, 100, ok);
    check("ptick_reach_spin", ok, 1);
    repeat (3) step();          // prescaler now at T-1
    timer_pause = 1'b1;
    step();
    check("ptick_hold_state", state, ST_SPIN);
    check("ptick_hold_sec", sec_left, 1);
    repeat (5) step();
    check("ptick_hold2_state", state, ST_SPIN);
    check("ptick_hold2_sec", sec_left, 1);
    timer_pause = 1'b0;
    step();
    check("ptick_resume_idle", state, ST_IDLE);
    check("ptick_resume_done", wash_done, 1);
    step();

    // Reset during the second RINSE of a double wash
    coin_pulse(2'd0, 1'b1);
    t = 0;
    while (!(state === ST_RINSE && wash_pass === 1'b1) && t < 100) begin
      step();
      t++;
    end
    check("rst_mid_reach", (state === ST_RINSE && wash_pass === 1'b1), 1);
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", state, ST_IDLE);
    check("rst_mid_sec", sec_left, 0);
    check("rst_mid_pass", wash_pass, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", wash_done, 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      step();
      if (wash_done !== 1'b0) seen++;
    end
    check("rst_mid_no_done", seen, 0);
    check("rst_mid_stay_idle", state, ST_IDLE);
    coin_pulse(2'd0, 1'b0);
    check("rst_restart_state", state, ST_FILL);
    check("rst_restart_sec", sec_left, 2);
    check("rst_restart_pass", wash_pass, 0);
    wait_state(ST_IDLE, 100, ok);
    check("rst_restart_finish", ok, 1);
    step();

    // Back-to-back: coin held high
    clk_freq    = 2'd0;
    double_wash = 1'b0;
    coin_in     = 1'b1;
    t = 0; first = -1; second = -1;
    while (second < 0 && t < 200) begin
      step();
      t++;
      if (first >= 0 && t == first + 1) check("b2b_refill", state, ST_FILL);
      if (wash_done === 1'b1) begin
        if (first < 0) first = t;
        else second = t;
      end
    end
    coin_in = 1'b0;
    check("b2b_first", first, 33);
    check("b2b_period", second - first, 33);
    step();
    check("b2b_stop_idle", state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
